// File: rtl/sram_sp_banked_lp_wrap_if.sv
// rtl/sram_sp_banked_lp_wrap_if.sv - request/response bus of the banked low-power SRAM wrapper
//
// Signals (requester view, modport master):
//   ME    out  access request
//   WE    out  DW/8 byte write enables (any set = write, none = read)
//   ADR   out  AW word address (bank select on top bits, row below)
//   D     out  DW write data
//   Q     in   DW read data, valid the cycle after a read is accepted
//   ready in   access accepted this cycle when ME=1
interface sram_sp_banked_lp_wrap_if #(
    parameter int DW = 32,
    parameter int AW = 13
);
    logic              ME;
    logic [DW/8-1:0]   WE;
    logic [AW-1:0]     ADR;
    logic [DW-1:0]     D;
    logic [DW-1:0]     Q;
    logic              ready;

    modport master (output ME, WE, ADR, D, input Q, ready);
    modport slave  (input ME, WE, ADR, D, output Q, ready);
endinterface

// File: rtl/generic_sram_bit.sv
// rtl/generic_sram_bit.sv - single-port SRAM macro model with per-bit write mask
//
// Ports:
//   CLK   in  clock
//   n_cs  in  active-low chip select
//   n_we  in  active-low write enable
//   mask  in  DW per-bit write mask, 1 = bit keeps its old value
//   A     in  AW row address
//   D     in  DW write data
//   Q     out DW read data, registered, holds across writes and idle cycles
module generic_sram_bit #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          n_cs,
    input  logic          n_we,
    input  logic [DW-1:0] mask,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (!n_cs) begin
            if (!n_we) begin
                mem[A] <= (mem[A] & mask) | (D & ~mask);
            end else begin
                Q <= mem[A];
            end
        end
    end
endmodule

// File: rtl/sram_sp_banked_lp_wrap.sv
// rtl/sram_sp_banked_lp_wrap.sv - banked single-port SRAM wrapper with per-bank light sleep
//
// Optional feature macro: SRAM_WRAP_ERR_EN (adds err output).
//
// Ports:
//   CLK        in   clock
//   reset_n    in   asynchronous active-low reset
//   scan_mode  in   1 = every bank held ACTIVE, sleep disabled
//   bus        slave request/response bus (ME, WE, ADR, D, Q, ready)
//   bank_ls    out  NUM_BANKS per-bank light-sleep indication
//   err        out  1-cycle pulse after an accepted out-of-range access (SRAM_WRAP_ERR_EN only)
module sram_sp_banked_lp_wrap #(
    parameter int DW          = 32,
    parameter int BANK_AW     = 12,
    parameter int NUM_BANKS   = 2,
    parameter int SEL_W       = 1,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  scan_mode,
    sram_sp_banked_lp_wrap_if.slave bus,
    output logic [NUM_BANKS-1:0]  bank_ls
`ifdef SRAM_WRAP_ERR_EN
    ,
    output logic                  err
`endif
);
    typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} bank_state_e;

    localparam int         NB_BYTES  = DW / 8;
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    logic [SEL_W-1:0]              bank_idx;
    logic [BANK_AW-1:0]            row;
    logic                          oor;
    logic                          any_we;
    logic                          accept;
    logic [NUM_BANKS-1:0]          tgt;
    logic [NUM_BANKS-1:0]          sleep_due;
    logic [NUM_BANKS-1:0]          can_accept;
    logic [NUM_BANKS-1:0]          acc_bank;
    logic [DW-1:0]                 bit_mask;
    logic [DW-1:0]                 dout [NUM_BANKS];

    bank_state_e [NUM_BANKS-1:0]   state_q, state_d;
    logic [NUM_BANKS-1:0][7:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    logic                          oor_q, oor_d;

    assign bank_idx = bus.ADR[BANK_AW+SEL_W-1:BANK_AW];
    assign row      = bus.ADR[BANK_AW-1:0];
    assign oor      = (int'(bank_idx) >= NUM_BANKS);
    assign any_we   = |bus.WE;

    // A bank whose idle counter expires this cycle is already committed to
    // SLEEP, so it refuses the access and wakes on the following cycle.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            tgt[b]        = !oor && (bank_idx == SEL_W'(b));
            sleep_due[b]  = (IDLE_CYCLES != 0) && (state_q[b] == ST_ACTIVE) && (cnt_q[b] == IDLE_LAST);
            can_accept[b] = scan_mode || ((state_q[b] == ST_ACTIVE) && !sleep_due[b]);
        end
    end

    assign bus.ready = !bus.ME || oor || |(tgt & can_accept);
    assign accept    = bus.ME && bus.ready;
    assign acc_bank  = {NUM_BANKS{accept}} & tgt;

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < NB_BYTES; k++) begin
            bit_mask[8*k +: 8] = {8{~bus.WE[k]}};
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        generic_sram_bit #(.DW(DW), .AW(BANK_AW)) u_mem (
            .CLK  (CLK),
            .n_cs (~acc_bank[g]),
            .n_we (~(accept & any_we)),
            .mask (bit_mask),
            .A    (row),
            .D    (bus.D),
            .Q    (dout[g])
        );
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            if (scan_mode) begin
                state_d[b] = ST_ACTIVE;
                cnt_d[b]   = '0;
            end else begin
                case (state_q[b])
                    ST_ACTIVE: begin
                        if (acc_bank[b]) begin
                            cnt_d[b] = '0;
                        end else if (sleep_due[b]) begin
                            state_d[b] = ST_SLEEP;
                            cnt_d[b]   = '0;
                        end else if (IDLE_CYCLES != 0) begin
                            cnt_d[b] = cnt_q[b] + 8'd1;
                        end
                    end
                    ST_SLEEP: begin
                        if (bus.ME && tgt[b]) begin
                            state_d[b] = ST_WAKE;
                            cnt_d[b]   = WAKE_LOAD;
                        end
                    end
                    ST_WAKE: begin
                        if (cnt_q[b] == 8'd0) begin
                            state_d[b] = ST_ACTIVE;
                        end else begin
                            cnt_d[b] = cnt_q[b] - 8'd1;
                        end
                    end
                    default: begin
                        state_d[b] = ST_ACTIVE;
                        cnt_d[b]   = '0;
                    end
                endcase
            end
        end
    end

    // Read-mux select only moves on accepted reads; writes leave Q on the last read bank.
    always_comb begin
        sel_d = sel_q;
        oor_d = oor_q;
        if (accept && !any_we) begin
            oor_d = oor;
            if (!oor) begin
                sel_d = bank_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= ST_ACTIVE;
            end
            cnt_q <= '0;
            sel_q <= '0;
            oor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_ls[b] = (state_q[b] == ST_SLEEP);
        end
    end

    always_comb begin
        bus.Q = '0;
        if (!oor_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (sel_q == SEL_W'(b)) begin
                    bus.Q = dout[b];
                end
            end
        end
    end

`ifdef SRAM_WRAP_ERR_EN
    logic err_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && oor;
        end
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_sram_sp_banked_lp_wrap.sv
// tb/tb_sram_sp_banked_lp_wrap.sv - directed self-checking bench for sram_sp_banked_lp_wrap
module tb_sram_sp_banked_lp_wrap;
    logic       CLK;
    logic       reset_n;
    logic       scan_mode;
    logic [1:0] ls_a;
    logic [2:0] ls_3;
`ifdef SRAM_WRAP_ERR_EN
    logic       err_a;
    logic       err_3;
`endif
    int checks   = 0;
    int failures = 0;

    sram_sp_banked_lp_wrap_if #(.DW(32), .AW(13)) bus_a ();
    sram_sp_banked_lp_wrap_if #(.DW(32), .AW(14)) bus_3 ();

    sram_sp_banked_lp_wrap #(
        .DW(32), .BANK_AW(12), .NUM_BANKS(2), .SEL_W(1), .IDLE_CYCLES(16), .WAKE_CYCLES(2)
    ) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .scan_mode (scan_mode),
        .bus       (bus_a),
        .bank_ls   (ls_a)
`ifdef SRAM_WRAP_ERR_EN
        ,
        .err       (err_a)
`endif
    );

    sram_sp_banked_lp_wrap #(
        .DW(32), .BANK_AW(12), .NUM_BANKS(3), .SEL_W(2), .IDLE_CYCLES(16), .WAKE_CYCLES(2)
    ) dut3 (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .scan_mode (scan_mode),
        .bus       (bus_3),
        .bank_ls   (ls_3)
`ifdef SRAM_WRAP_ERR_EN
        ,
        .err       (err_3)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_access(input logic [3:0] we, input logic [12:0] adr, input logic [31:0] d,
                             output int waits);
        bus_a.ME  = 1'b1;
        bus_a.WE  = we;
        bus_a.ADR = adr;
        bus_a.D   = d;
        #1;
        waits = 0;
        while (bus_a.ready !== 1'b1 && waits < 20) begin
            step();
            waits++;
        end
        if (bus_a.ready !== 1'b1) begin
            waits = -1;
        end else begin
            step();
        end
        bus_a.ME = 1'b0;
        bus_a.WE = 4'h0;
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        scan_mode = 1'b0;
        bus_a.ME = 1'b1; bus_a.WE = 4'h0; bus_a.ADR = 13'h1000; bus_a.D = '0;
        bus_3.ME = 1'b0; bus_3.WE = 4'h0; bus_3.ADR = 14'h0000; bus_3.D = '0;
        step();
        step();
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", bus_a.ready);
        end
        checks++;
        if (ls_a !== 2'b00) begin
            failures++; $display("FAIL reset_bank_ls got=%b exp=00", ls_a);
        end
        checks++;
        if (ls_3 !== 3'b000) begin
            failures++; $display("FAIL reset_bank_ls3 got=%b exp=000", ls_3);
        end
`ifdef SRAM_WRAP_ERR_EN
        checks++;
        if (err_a !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", err_a);
        end
`endif
        bus_a.ME = 1'b0;
        reset_n  = 1'b1;
        #1;
    endtask

    task automatic test_out_of_range();
        bus_3.ME = 1'b1; bus_3.WE = 4'hF; bus_3.ADR = 14'h0007; bus_3.D = 32'h0BAD_CAFE;
        #1;
        checks++;
        if (bus_3.ready !== 1'b1) begin
            failures++; $display("FAIL oor_pre_write_ready got=%b exp=1", bus_3.ready);
        end
        step();
        bus_3.WE = 4'h0;
        #1;
        step();
        bus_3.ADR = 14'h3000;
        #1;
        checks++;
        if (bus_3.Q !== 32'h0BAD_CAFE) begin
            failures++; $display("FAIL oor_pre_read_q got=%h exp=0badcafe", bus_3.Q);
        end
        checks++;
        if (bus_3.ready !== 1'b1) begin
            failures++; $display("FAIL oor_ready got=%b exp=1", bus_3.ready);
        end
        step();
        bus_3.ME = 1'b0;
        #1;
        checks++;
        if (bus_3.Q !== 32'h0) begin
            failures++; $display("FAIL oor_q_zero got=%h exp=00000000", bus_3.Q);
        end
`ifdef SRAM_WRAP_ERR_EN
        checks++;
        if (err_3 !== 1'b1) begin
            failures++; $display("FAIL oor_err_pulse got=%b exp=1", err_3);
        end
`endif
        step();
`ifdef SRAM_WRAP_ERR_EN
        checks++;
        if (err_3 !== 1'b0) begin
            failures++; $display("FAIL oor_err_clear got=%b exp=0", err_3);
        end
`endif
        checks++;
        if (bus_3.Q !== 32'h0) begin
            failures++; $display("FAIL oor_q_hold got=%h exp=00000000", bus_3.Q);
        end
    endtask

    task automatic test_write_read();
        bus_a.ME = 1'b1; bus_a.WE = 4'hF; bus_a.ADR = 13'h0005; bus_a.D = 32'hA5A5_1234;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL wr_ready got=%b exp=1", bus_a.ready);
        end
        step();
        bus_a.WE = 4'h0;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL rd_ready got=%b exp=1", bus_a.ready);
        end
        step();
        bus_a.ME = 1'b0;
        #1;
        checks++;
        if (bus_a.Q !== 32'hA5A5_1234) begin
            failures++; $display("FAIL rd_data got=%h exp=a5a51234", bus_a.Q);
        end
    endtask

    task automatic test_byte_lanes();
        int w;
        do_access(4'hF, 13'h1010, 32'hFFFF_FFFF, w);
        do_access(4'h5, 13'h1010, 32'h0000_0000, w);
        do_access(4'hF, 13'h1003, 32'hC0DE_1003, w);
        do_access(4'h0, 13'h1010, 32'h0000_0000, w);
        checks++;
        if (w < 0) begin
            failures++; $display("FAIL byte_lane_timeout got=%0d exp>=0", w);
        end
        checks++;
        if (bus_a.Q !== 32'hFF00_FF00) begin
            failures++; $display("FAIL byte_lane_data got=%h exp=ff00ff00", bus_a.Q);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [12:0] adrs [3];
        logic [31:0] exps [3];
        adrs[0] = 13'h1001; adrs[1] = 13'h0001; adrs[2] = 13'h1001;
        exps[0] = 32'h11;   exps[1] = 32'h22;   exps[2] = 32'h11;
        do_access(4'hF, 13'h0001, 32'h11, w);
        do_access(4'hF, 13'h1001, 32'h22, w);
        bus_a.ME = 1'b1; bus_a.WE = 4'h0; bus_a.ADR = 13'h0001;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready0 got=%b exp=1", bus_a.ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            bus_a.ADR = adrs[i];
            if (i == 2) begin
                bus_a.WE = 4'hF;
                bus_a.D  = 32'h99;
            end
            #1;
            checks++;
            if (bus_a.Q !== exps[i]) begin
                failures++; $display("FAIL b2b_q%0d got=%h exp=%h", i, bus_a.Q, exps[i]);
            end
            checks++;
            if (bus_a.ready !== 1'b1) begin
                failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i + 1, bus_a.ready);
            end
        end
        step();
        bus_a.ME = 1'b0;
        bus_a.WE = 4'h0;
        #1;
        checks++;
        if (bus_a.Q !== 32'h11) begin
            failures++; $display("FAIL b2b_q_after_write got=%h exp=00000011", bus_a.Q);
        end
    endtask

    task automatic test_sleep_wake();
        repeat (15) step();
        checks++;
        if (ls_a !== 2'b01) begin
            failures++; $display("FAIL idle15_ls got=%b exp=01", ls_a);
        end
        step();
        checks++;
        if (ls_a !== 2'b11) begin
            failures++; $display("FAIL idle16_ls got=%b exp=11", ls_a);
        end
        bus_a.ME = 1'b1; bus_a.WE = 4'h0; bus_a.ADR = 13'h1003;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus_a.ready !== 1'b0) begin
                failures++; $display("FAIL wake_ready_t%0d got=%b exp=0", c, bus_a.ready);
            end
            if (c == 1) begin
                checks++;
                if (ls_a !== 2'b01) begin
                    failures++; $display("FAIL wake_ls got=%b exp=01", ls_a);
                end
            end
            step();
        end
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL wake_ready_t3 got=%b exp=1", bus_a.ready);
        end
        checks++;
        if (ls_a !== 2'b01) begin
            failures++; $display("FAIL wake_ls_t3 got=%b exp=01", ls_a);
        end
        step();
        bus_a.ME = 1'b0;
        #1;
        checks++;
        if (bus_a.Q !== 32'hC0DE_1003) begin
            failures++; $display("FAIL wake_data got=%h exp=c0de1003", bus_a.Q);
        end
    endtask

    task automatic test_sleep_collision();
        repeat (15) step();
        bus_a.ME = 1'b1; bus_a.WE = 4'h0; bus_a.ADR = 13'h1000;
        #1;
        checks++;
        if (bus_a.ready !== 1'b0) begin
            failures++; $display("FAIL collide_ready got=%b exp=0", bus_a.ready);
        end
        step();
        checks++;
        if (ls_a !== 2'b11) begin
            failures++; $display("FAIL collide_sleep_ls got=%b exp=11", ls_a);
        end
        step();
        step();
        checks++;
        if (bus_a.ready !== 1'b0) begin
            failures++; $display("FAIL collide_ready_t2 got=%b exp=0", bus_a.ready);
        end
        step();
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL collide_ready_t3 got=%b exp=1", bus_a.ready);
        end
        step();
        bus_a.ME = 1'b0;
        #1;
    endtask

    task automatic test_scan_and_reset();
        scan_mode = 1'b1;
        repeat (40) step();
        checks++;
        if (ls_a !== 2'b00) begin
            failures++; $display("FAIL scan_ls got=%b exp=00", ls_a);
        end
        bus_a.ME = 1'b1; bus_a.WE = 4'h0; bus_a.ADR = 13'h1000;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL scan_ready got=%b exp=1", bus_a.ready);
        end
        bus_a.ME  = 1'b0;
        scan_mode = 1'b0;
        repeat (15) step();
        checks++;
        if (ls_a !== 2'b00) begin
            failures++; $display("FAIL scan_exit15_ls got=%b exp=00", ls_a);
        end
        step();
        checks++;
        if (ls_a !== 2'b11) begin
            failures++; $display("FAIL scan_exit16_ls got=%b exp=11", ls_a);
        end
        bus_a.ME = 1'b1; bus_a.ADR = 13'h1000;
        step();
        checks++;
        if (ls_a !== 2'b01 || bus_a.ready !== 1'b0) begin
            failures++; $display("FAIL midwake_state got=ls%b/rdy%b exp=ls01/rdy0", ls_a, bus_a.ready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_a.ready !== 1'b1) begin
            failures++; $display("FAIL midwake_reset_ready got=%b exp=1", bus_a.ready);
        end
        checks++;
        if (ls_a !== 2'b00) begin
            failures++; $display("FAIL midwake_reset_ls got=%b exp=00", ls_a);
        end
        bus_a.ME = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_out_of_range();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_sleep_wake();
        test_sleep_collision();
        test_scan_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
